audio_i2s_out: RTL



---
 rtl/audio_i2s_out.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/audio_i2s_out.sv
// audio_i2s_out: mixes the PSG and PCM stereo samples with saturation and
// serializes the result to an external DAC over I2S. It also issues the
// per-frame next_sample strobe that starts the PSG channel sweep.
//
// Frame = 64 bit slots, slot = 2*BCLK_DIV clk, so a frame is 128*BCLK_DIV clk.
// The mix is captured in the frame-start cycle and shifted out in that frame.
//
// Optional build macro AUDIO_I2S_OUT_LEFT_JUSTIFIED_EN selects the
// left-justified format: no one-slot data delay, and lrck is 1 for left.
// lrck stays 0 in reset and IDLE in either format.
module audio_i2s_out #(
    parameter int BCLK_DIV = 4   // clk cycles per bclk half-period, 2..255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic [15:0] psg_left,
    input  logic [15:0] psg_right,
    input  logic [15:0] pcm_left,
    input  logic [15:0] pcm_right,
    output logic        next_sample,
    output logic        i2s_bclk,
    output logic        i2s_lrck,
    output logic        i2s_data
);

    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [7:0] DIV_LAST = 8'(BCLK_DIV - 1);

`ifdef AUDIO_I2S_OUT_LEFT_JUSTIFIED_EN
    localparam logic LRCK_LEFT = 1'b1;
`else
    localparam logic LRCK_LEFT = 1'b0;
`endif

    // Saturating 16-bit signed add: overflow shows as bit16 != bit15 of the 17-bit sum.
    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {a[15], a} + {b[15], b};
        if (!sum[16] && sum[15])
            return 16'h7FFF;
        else if (sum[16] && !sum[15])
            return 16'h8000;
        else
            return sum[15:0];
    endfunction

    // Serial bit driven during a given slot for the given left/right samples.
    function automatic logic slot_bit(input logic [5:0] slot, input logic [15:0] l,
                                      input logic [15:0] r);
        logic [15:0] smp;
        smp = slot[5] ? r : l;
`ifdef AUDIO_I2S_OUT_LEFT_JUSTIFIED_EN
        // k = 0..15 carries sample[15-k]; 15-k == ~k[3:0].
        return !slot[4] && smp[~slot[3:0]];
`else
        // k = 1..16 carries sample[16-k]; with m = k-1 that is sample[~m[3:0]].
        // k = 0 wraps m to 31, so m[4] flags every padding slot.
        begin
            logic [4:0] m;
            m = slot[4:0] - 5'd1;
            return !m[4] && smp[~m[3:0]];
        end
`endif
    endfunction

    state_t      state, state_nx;
    logic [7:0]  div_cnt, div_cnt_nx;
    logic [5:0]  slot_cnt, slot_cnt_nx;
    logic [15:0] left_sh, left_sh_nx;
    logic [15:0] right_sh, right_sh_nx;
    logic        next_sample_nx, bclk_nx, lrck_nx, data_nx;
    logic [15:0] mix_l, mix_r;
    logic [5:0]  slot_inc;
    logic        slot_end;

    assign mix_l    = sat16(psg_left, pcm_left);
    assign mix_r    = sat16(psg_right, pcm_right);
    assign slot_inc = slot_cnt + 6'd1;
    // Last clk of a slot: final div count of the bclk-high half.
    assign slot_end = (div_cnt == DIV_LAST) && i2s_bclk;

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    // Next-state logic: enable starts and aborts the serializer.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (enable)  state_nx = RUN;
            RUN:     if (!enable) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output/datapath next values; all outputs are registered below.
    always_comb begin
        // NOTE: defaults first on every signal so no path infers a latch.
        div_cnt_nx     = '0;
        slot_cnt_nx    = '0;
        left_sh_nx     = left_sh;
        right_sh_nx    = right_sh;
        next_sample_nx = 1'b0;
        bclk_nx        = 1'b0;
        lrck_nx        = 1'b0;
        data_nx        = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    // Entry cycle into RUN is a frame start at slot 0.
                    next_sample_nx = 1'b1;
                    lrck_nx        = LRCK_LEFT;
                end
            end
            RUN: begin
                if (enable) begin
                    div_cnt_nx  = (div_cnt == DIV_LAST) ? 8'd0 : div_cnt + 8'd1;
                    bclk_nx     = (div_cnt == DIV_LAST) ? ~i2s_bclk : i2s_bclk;
                    slot_cnt_nx = slot_cnt;
                    lrck_nx     = i2s_lrck;
                    data_nx     = i2s_data;
                    if (next_sample) begin
                        // Frame-start cycle: capture the mix, refresh slot-0 data from it.
                        left_sh_nx  = mix_l;
                        right_sh_nx = mix_r;
                        data_nx     = slot_bit(slot_cnt, mix_l, mix_r);
                    end
                    if (slot_end) begin
                        slot_cnt_nx    = slot_inc;
                        lrck_nx        = slot_inc[5] ^ LRCK_LEFT;
                        data_nx        = slot_bit(slot_inc, left_sh, right_sh);
                        next_sample_nx = (slot_inc == 6'd0);
                    end
                end
            end
            default: ;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt     <= '0;
            slot_cnt    <= '0;
            left_sh     <= '0;
            right_sh    <= '0;
            next_sample <= 1'b0;
            i2s_bclk    <= 1'b0;
            i2s_lrck    <= 1'b0;
            i2s_data    <= 1'b0;
        end else begin
            div_cnt     <= div_cnt_nx;
            slot_cnt    <= slot_cnt_nx;
            left_sh     <= left_sh_nx;
            right_sh    <= right_sh_nx;
            next_sample <= next_sample_nx;
            i2s_bclk    <= bclk_nx;
            i2s_lrck    <= lrck_nx;
            i2s_data    <= data_nx;
        end
    end

endmodule
